// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package irq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        PUSH   = 3'd2,
        VECT   = 3'd3,
        ACTIVE = 3'd4
    } state_t;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_EN   = 2'd1;
    localparam logic [1:0] CFG_CLR  = 2'd2;
    localparam logic [1:0] CFG_PEND = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible request vector.
module irq_prio_enc #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt controller: edge-latched pending bits, mask/enable, fixed priority,
// and the stall / push-return-PC / redirect entry sequence.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int                NUM_IRQ    = 8,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0010,
    parameter int                VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [NUM_IRQ-1:0] cfg_wdata,
    output logic [NUM_IRQ-1:0] cfg_rdata,
    input  logic               pipe_drained,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               reti_in,
    output logic               int_req,
    output logic               push_en,
    output logic [ADDR_W-1:0]  push_data,
    output logic               vec_valid,
    output logic [ADDR_W-1:0]  vec_addr,
    output logic               in_service,
    output logic [3:0]         active_id,
    output logic [2:0]         dbg_state
);

    localparam int STRIDE_SH = $clog2(VEC_STRIDE);

    state_t             state;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic               enable;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr_cfg;
    logic [NUM_IRQ-1:0] clr_take;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic               sel_valid;
    logic [3:0]         sel_id;
    logic               take;

    assign rise     = irq_in & ~irq_q;
    assign eligible = enable ? (pending & mask) : '0;

    irq_prio_enc #(
        .NUM_IRQ(NUM_IRQ)
    ) u_prio_enc (
        .req  (eligible),
        .valid(sel_valid),
        .id   (sel_id)
    );

    assign take = (state == IDLE) && sel_valid;

    always_comb begin
        clr_take = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_take[i] = take && (sel_id == 4'(i));
        end
    end

    assign clr_cfg = (cfg_we && (cfg_addr == CFG_CLR)) ? cfg_wdata : '0;

    // A new edge in the same cycle as a clear keeps the bit set.
    assign pending_nxt = (pending & ~(clr_cfg | clr_take)) | rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
            enable  <= 1'b0;
        end else begin
            irq_q   <= irq_in;
            pending <= pending_nxt;
            if (cfg_we && (cfg_addr == CFG_MASK)) begin
                mask <= cfg_wdata;
            end
            if (cfg_we && (cfg_addr == CFG_EN)) begin
                enable <= cfg_wdata[0];
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_MASK: cfg_rdata = mask;
            CFG_EN:   cfg_rdata[0] = enable;
            CFG_PEND: cfg_rdata = pending;
            default:  cfg_rdata = '0;
        endcase
    end

    // Pipeline handshake: int_req is held high from REQ through VECT and only
    // advances past REQ on a cycle where pipe_drained is sampled high;
    // push_en and vec_valid are single-cycle strobes the pipeline cannot stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            push_en    <= 1'b0;
            push_data  <= '0;
            vec_valid  <= 1'b0;
            in_service <= 1'b0;
            active_id  <= 4'd0;
        end else begin
            push_en   <= 1'b0;
            vec_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state     <= REQ;
                        active_id <= sel_id;
                        int_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (pipe_drained) begin
                        state     <= PUSH;
                        push_data <= pc_in;
                        push_en   <= 1'b1;
                    end
                end
                PUSH: begin
                    state     <= VECT;
                    vec_valid <= 1'b1;
                end
                VECT: begin
                    state      <= ACTIVE;
                    int_req    <= 1'b0;
                    in_service <= 1'b1;
                end
                ACTIVE: begin
                    if (reti_in) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

    assign vec_addr  = VEC_BASE + (ADDR_W'(active_id) << STRIDE_SH);
    assign dbg_state = state;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: entry timing, priority, masking, drain stall,
// no-nesting, set-beats-clear and reset abort.
module tb_irq_sequencer;

  localparam int NUM_IRQ = 8;
  localparam int ADDR_W  = 16;

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic               pipe_drained;
  logic [ADDR_W-1:0]  pc_in;
  logic               reti_in;
  logic               int_req;
  logic               push_en;
  logic [ADDR_W-1:0]  push_data;
  logic               vec_valid;
  logic [ADDR_W-1:0]  vec_addr;
  logic               in_service;
  logic [3:0]         active_id;
  logic [2:0]         dbg_state;

  int n_total;
  int n_pass;

  irq_sequencer #(
    .NUM_IRQ   (NUM_IRQ),
    .ADDR_W    (ADDR_W),
    .VEC_BASE  (16'h0010),
    .VEC_STRIDE(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_in      (irq_in),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .pipe_drained(pipe_drained),
    .pc_in       (pc_in),
    .reti_in     (reti_in),
    .int_req     (int_req),
    .push_en     (push_en),
    .push_data   (push_data),
    .vec_valid   (vec_valid),
    .vec_addr    (vec_addr),
    .in_service  (in_service),
    .active_id   (active_id),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    cfg_addr = addr;
    #1;
    chk(tag, 32'(cfg_rdata), exp);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [NUM_IRQ-1:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic reti_pulse();
    reti_in = 1'b1;
    step();
    reti_in = 1'b0;
  endtask

  initial begin
    n_total      = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    irq_in       = '0;
    cfg_we       = 1'b0;
    cfg_addr     = 2'd0;
    cfg_wdata    = '0;
    pipe_drained = 1'b1;
    pc_in        = 16'h0120;
    reti_in      = 1'b0;
    step();
    step();

    // reset state
    chk("rst_int_req", 32'(int_req), 0);
    chk("rst_push_en", 32'(push_en), 0);
    chk("rst_vec_valid", 32'(vec_valid), 0);
    chk("rst_in_service", 32'(in_service), 0);
    chk("rst_active_id", 32'(active_id), 0);
    chk("rst_push_data", 32'(push_data), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rd("rst_mask", 2'd0, 0);
    rd("rst_pend", 2'd3, 0);
    rst_n = 1'b1;

    cfg_write(2'd0, 8'hFF);
    cfg_write(2'd1, 8'h01);
    rd("cfg_mask_rd", 2'd0, 32'hFF);
    rd("cfg_en_rd", 2'd1, 32'h01);

    // single source 3, drained pipe
    irq_in = 8'h08;
    step();
    irq_in = 8'h00;
    rd("t1_pend", 2'd3, 32'h08);
    chk("t1_noreq_n1", 32'(int_req), 0);
    step();
    chk("t1_int_req", 32'(int_req), 1);
    chk("t1_active_id", 32'(active_id), 3);
    rd("t1_pend_clr", 2'd3, 0);
    step();
    chk("t1_push_en", 32'(push_en), 1);
    chk("t1_push_data", 32'(push_data), 32'h0120);
    step();
    chk("t1_vec_valid", 32'(vec_valid), 1);
    chk("t1_vec_addr", 32'(vec_addr), 32'h001C);
    chk("t1_push_once", 32'(push_en), 0);
    step();
    chk("t1_in_service", 32'(in_service), 1);
    chk("t1_req_drop", 32'(int_req), 0);
    chk("t1_vec_once", 32'(vec_valid), 0);
    reti_pulse();
    chk("t1_reti_svc", 32'(in_service), 0);
    chk("t1_reti_idle", 32'(dbg_state), 0);

    // simultaneous sources 5 and 2
    irq_in = 8'h24;
    step();
    irq_in = 8'h00;
    rd("t2_pend", 2'd3, 32'h24);
    step();
    chk("t2_first_id", 32'(active_id), 2);
    step();
    step();
    chk("t2_first_vec", 32'(vec_addr), 32'h0018);
    chk("t2_first_vv", 32'(vec_valid), 1);
    step();
    rd("t2_pend5_wait", 2'd3, 32'h20);
    chk("t2_no_nest", 32'(in_service), 1);
    reti_pulse();
    chk("t2_idle_gap", 32'(int_req), 0);
    step();
    chk("t2_second_req", 32'(int_req), 1);
    chk("t2_second_id", 32'(active_id), 5);
    step();
    step();
    chk("t2_second_vec", 32'(vec_addr), 32'h0024);
    chk("t2_second_vv", 32'(vec_valid), 1);
    step();
    reti_pulse();

    // masked source 1, then unmask
    cfg_write(2'd0, 8'h00);
    irq_in = 8'h02;
    step();
    irq_in = 8'h00;
    rd("t3_pend", 2'd3, 32'h02);
    step();
    chk("t3_masked_a", 32'(int_req), 0);
    step();
    chk("t3_masked_b", 32'(int_req), 0);
    cfg_write(2'd0, 8'h02);
    chk("t3_unmask_gap", 32'(int_req), 0);
    pipe_drained = 1'b0;
    pc_in        = 16'h0ABC;
    step();
    chk("t3_req", 32'(int_req), 1);
    chk("t3_id", 32'(active_id), 1);

    // drain stall for six low samples
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_req", 32'(int_req), 1);
      chk("t4_stall_nopush", 32'(push_en), 0);
    end
    pipe_drained = 1'b1;
    step();
    chk("t4_push_after", 32'(push_en), 1);
    chk("t4_push_data", 32'(push_data), 32'h0ABC);
    step();
    chk("t4_vec_addr", 32'(vec_addr), 32'h0014);
    step();
    chk("t4_active", 32'(in_service), 1);

    // edge during ACTIVE together with a clear of the same bit
    cfg_write(2'd0, 8'hFF);
    irq_in    = 8'h01;
    cfg_we    = 1'b1;
    cfg_addr  = 2'd2;
    cfg_wdata = 8'h01;
    step();
    irq_in    = 8'h00;
    cfg_we    = 1'b0;
    cfg_wdata = '0;
    rd("t5_set_wins", 2'd3, 32'h01);
    step();
    step();
    chk("t5_no_entry", 32'(int_req), 0);
    chk("t5_keep_id", 32'(active_id), 1);
    rd("t5_pend_held", 2'd3, 32'h01);
    cfg_write(2'd2, 8'h01);
    rd("t5_pend_cleared", 2'd3, 0);
    reti_pulse();
    chk("t5_back_idle", 32'(dbg_state), 0);
    reti_pulse();
    chk("t5_reti_idle_state", 32'(dbg_state), 0);
    chk("t5_reti_idle_svc", 32'(in_service), 0);
    chk("t5_reti_idle_req", 32'(int_req), 0);

    // reset while in PUSH
    pc_in  = 16'h0777;
    irq_in = 8'h10;
    step();
    irq_in = 8'h00;
    step();
    step();
    chk("t6_in_push", 32'(push_en), 1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_vv", 32'(vec_valid), 0);
    chk("t6_rst_push", 32'(push_en), 0);
    chk("t6_rst_req", 32'(int_req), 0);
    chk("t6_rst_id", 32'(active_id), 0);
    chk("t6_rst_pdata", 32'(push_data), 0);
    chk("t6_rst_state", 32'(dbg_state), 0);
    rd("t6_rst_mask", 2'd0, 0);
    rd("t6_rst_en", 2'd1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_vec", 32'(vec_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt controller and entry sequencer for the core pipeline. It latches rising edges on external interrupt lines and applies a mask and a global enable. It picks one source by fixed priority and steps the pipeline through interrupt entry: stall fetch, push the return PC, then redirect to the vector. It then blocks further entry until the decoder reports a `reti`.

## Interface
Parameters:
- `NUM_IRQ`, 8: number of interrupt sources (1..16).
- `ADDR_W`, 16: PC/vector width.
- `VEC_BASE`, 16'h0010: address of vector 0.
- `VEC_STRIDE`, 4: byte spacing between vectors (power of two).

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `irq_in`  in  NUM_IRQ: external request lines, synchronous to `clk`.
- `cfg_we`  in  1: config write strobe.
- `cfg_addr`  in  2: 0 = mask, 1 = global enable (bit 0), 2 = clear pending (write-1-to-clear), 3 = pending (read-only).
- `cfg_wdata`  in  NUM_IRQ: write data.
- `cfg_rdata`  out  NUM_IRQ: combinational read of `cfg_addr`.
- `pipe_drained`  in  1: pipeline has no load, store or branch in flight.
- `pc_in`  in  ADDR_W: return address of the next unexecuted instruction.
- `reti_in`  in  1: one-cycle pulse from the decoder's `reti` on execute.
- `int_req`  out  1: hold fetch/flush request to the pipeline.
- `push_en`  out  1: one-cycle stack push strobe.
- `push_data`  out  ADDR_W: value to push (latched `pc_in`).
- `vec_valid`  out  1: one-cycle PC redirect strobe.
- `vec_addr`  out  ADDR_W: `VEC_BASE + active_id*VEC_STRIDE`, truncated to ADDR_W.
- `in_service`  out  1: handler running.
- `active_id`  out  4: selected source index.

## Operation
- Edge detect: `irq_q` registers `irq_in`. `pending[i]` sets on the edge where `irq_in[i]=1` and `irq_q[i]=0`. When the same bit is set and cleared in one cycle, the set wins.
- Eligible = `pending & mask`, gated by `enable`. The lowest index has highest priority.
- States:
  - IDLE: `int_req=0`.
    - Any eligible source goes to REQ. On that edge, latch `active_id` and clear that pending bit.
  - REQ: `int_req=1`.
    - Wait for `pipe_drained=1`. On that edge, latch `push_data<=pc_in` and go to PUSH.
  - PUSH: `int_req=1`, `push_en=1` for exactly one cycle, then go to VECT.
  - VECT: `int_req=1`, `vec_valid=1` for exactly one cycle, then go to ACTIVE.
  - ACTIVE: `in_service=1`, `int_req=0`.
    - `reti_in` goes to IDLE.
    - New edges still set pending bits. No nesting.
- Once REQ is entered, entry is committed. Clearing mask, enable or pending after that point does not cancel it.
- `reti_in` outside ACTIVE is ignored.
- Reset values:
  - State is IDLE.
  - `pending`, `mask`, `enable` and `irq_q` are 0.
  - `active_id` and `push_data` are 0.
  - All strobes, `int_req` and `in_service` are 0.
- Asserting reset in any state aborts entry immediately. No partial push or redirect strobe appears after the reset edge.

## Timing
- Rising edge seen at edge N: pending is visible in cycle N+1. If eligible, `int_req` rises at N+2.
- With `pipe_drained` already high, `push_en` is at N+3, `vec_valid` at N+4 and `in_service` at N+5.
- `pipe_drained` low in REQ: stay in REQ, one cycle per low sample, no timeout.
- `reti_in` in ACTIVE returns to IDLE on the next edge. A waiting eligible source reaches REQ one cycle later, so there is a one-cycle IDLE minimum.
- Config writes take effect at the next edge.
- `cfg_rdata` reflects register state, not same-cycle writes.

## Structure
- `irq_pkg`: state enum (IDLE, REQ, PUSH, VECT, ACTIVE) and the `cfg_addr` constants CFG_MASK, CFG_EN, CFG_CLR and CFG_PEND.
- Sub-module `irq_prio_enc`: combinational lowest-index priority encoder, `NUM_IRQ` to `{valid, id[3:0]}`.
- Top-level holds the edge detect, config registers, FSM and vector arithmetic.

## Test plan
- Mask=0xFF, enable=1, pulse `irq_in[3]` with `pipe_drained=1` and `pc_in=0x0120`:
  - `int_req` at N+2.
  - `push_en` with `push_data=0x0120` at N+3.
  - `vec_valid` with `vec_addr=0x001C` at N+4.
  - `active_id=3`.
- Rising edges on sources 5 and 2 in the same cycle: source 2 serviced first with `vec_addr=0x0018`. After `reti_in`, source 5 is serviced with `vec_addr=0x0024`.
- Mask=0x00, edge on source 1: `pending=0x02`, no `int_req`. Then set mask=0x02: entry starts 1 cycle later.
- Hold `pipe_drained=0` for 6 cycles in REQ: `int_req` is held for those cycles and there is no `push_en`. Raise it and `push_en` follows on the next cycle.
- Edge on source 0 during ACTIVE: no entry and pending bit 0 stays set. A `reti_in` while IDLE has no effect.
- `rst_n=0` during PUSH: next cycle all outputs and registers are 0 and state is IDLE. No `vec_valid` ever appears.
